// File: rtl/stage_mem_lsu.sv
// MEM-stage load/store unit: byte-serial LOAD/STORE on an 8-bit RAM port,
// one write-back beat per op; non-memory ops pass through with one cycle latency.
module stage_mem_lsu #(
    parameter logic [6:0] LOAD_OP  = 7'b0000011,
    parameter logic [6:0] STORE_OP = 7'b0100011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        valid_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    output logic [31:0] mem_a_o,
    output logic [7:0]  mem_dout_o,
    output logic        mem_wr_o,
    input  logic [7:0]  mem_din_i,
    output logic        busy_o,
    output logic        wb_valid_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_STORE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state;
    logic [31:0] addr_q, data_q, a_q, a_comb, ld_res;
    logic [2:0]  f3_q, issue_q, cap_q, nbytes;
    logic [4:0]  wd_q;
    logic        wreg_q, is_load, is_store, capture, ld_last;

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   extend = f3[2] ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
            2'b01:   extend = f3[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    always_comb begin
        case (f3_q[1:0])
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    assign is_load  = (opcode_i == LOAD_OP);
    assign is_store = (opcode_i == STORE_OP);
    assign busy_o   = (state != S_IDLE) | (valid_i & (is_load | is_store));

    // A byte is on mem_din_i whenever more addresses were issued than captured.
    assign capture = (state == S_LOAD) && (cap_q < issue_q);
    assign ld_last = capture && ((cap_q + 3'd1) == nbytes);

    always_comb begin
        a_comb = '0;
        case (state)
            S_LOAD:  if (issue_q < nbytes) a_comb = addr_q + {29'd0, issue_q};
            S_STORE: a_comb = addr_q + {29'd0, issue_q};
            default: a_comb = '0;
        endcase
    end

    always_comb begin
        ld_res = data_q;
        ld_res[{cap_q[1:0], 3'b000} +: 8] = mem_din_i;
    end

    // While paused, the last presented address is held so a pending read byte survives.
    assign mem_a_o    = rdy ? a_comb : a_q;
    assign mem_wr_o   = rdy & (state == S_STORE);
    assign mem_dout_o = (state == S_STORE) ? data_q[{issue_q[1:0], 3'b000} +: 8] : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            a_q        <= '0;
            f3_q       <= '0;
            issue_q    <= '0;
            cap_q      <= '0;
            wd_q       <= '0;
            wreg_q     <= 1'b0;
            wb_valid_o <= 1'b0;
            wd_o       <= '0;
            wreg_o     <= 1'b0;
            wdata_o    <= '0;
        end else if (rdy) begin
            a_q        <= a_comb;
            wb_valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid_i) begin
                        if (is_load || is_store) begin
                            addr_q  <= mem_addr_i;
                            f3_q    <= funct3_i;
                            wd_q    <= wd_i;
                            wreg_q  <= wreg_i;
                            issue_q <= '0;
                            cap_q   <= '0;
                            data_q  <= is_store ? wdata_i : 32'd0;
                            state   <= is_store ? S_STORE : S_LOAD;
                        end else begin
                            wb_valid_o <= 1'b1;
                            wd_o       <= wd_i;
                            wreg_o     <= wreg_i & (wd_i != 5'd0);
                            wdata_o    <= wdata_i;
                        end
                    end
                end
                S_LOAD: begin
                    if (issue_q < nbytes) issue_q <= issue_q + 3'd1;
                    if (capture) begin
                        data_q <= ld_res;
                        cap_q  <= cap_q + 3'd1;
                    end
                    if (ld_last) begin
                        state      <= S_DONE;
                        wb_valid_o <= 1'b1;
                        wd_o       <= wd_q;
                        wreg_o     <= wreg_q & (wd_q != 5'd0);
                        wdata_o    <= extend(ld_res, f3_q);
                    end
                end
                S_STORE: begin
                    if (issue_q == (nbytes - 3'd1)) begin
                        state      <= S_DONE;
                        wb_valid_o <= 1'b1;
                        wd_o       <= wd_q;
                        wreg_o     <= 1'b0;
                        wdata_o    <= '0;
                    end else begin
                        issue_q <= issue_q + 3'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stage_mem_lsu.sv
// Randomized bench for stage_mem_lsu: a byte-array memory model predicts
// addresses, written bytes and write-back values for every transaction.
module tb_stage_mem_lsu;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] ALU = 7'b0110011;

    logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, valid = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] mem_addr = '0, wdata = '0;
    logic [4:0]  wd = '0;
    logic        wreg = 1'b0;
    logic [31:0] mem_a, wdata_o;
    logic [7:0]  mem_dout, mem_din;
    logic        mem_wr, busy, wb_valid, wreg_o;
    logic [4:0]  wd_o;

    int checks = 0, errors = 0;

    logic [7:0] ram [0:4095];
    logic [7:0] ref_mem [0:4095];
    logic       ram_ready = 1'b0;

    stage_mem_lsu dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .valid_i(valid),
        .opcode_i(opcode), .funct3_i(funct3), .mem_addr_i(mem_addr),
        .wdata_i(wdata), .wd_i(wd), .wreg_i(wreg),
        .mem_a_o(mem_a), .mem_dout_o(mem_dout), .mem_wr_o(mem_wr), .mem_din_i(mem_din),
        .busy_o(busy), .wb_valid_o(wb_valid), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) ^ (i >> 3));
    endfunction

    // RAM responder: synchronous read, data valid the cycle after the address.
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 4096; i++) ram[i] <= init_byte(i);
            ram_ready <= 1'b1;
        end else begin
            if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
            mem_din <= ram[mem_a[11:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // pause_mode: 0 none, 1 random pauses, 2 three paused cycles after the 2nd issue
    task automatic mem_op(input logic is_st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [4:0] rd, input logic we,
                          input int pause_mode);
        int n, k, paused, busy_cnt;
        logic [31:0] exp, prev_a, ai;
        logic seen;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        exp = '0;
        for (int i = 0; i < n; i++) begin
            ai = a + i;
            if (is_st) ref_mem[ai[11:0]] = 8'(d >> (8 * i));
            else exp = exp | (32'(ref_mem[ai[11:0]]) << (8 * i));
        end
        if (!is_st && !f3[2] && n < 4 && exp[8 * n - 1]) exp = exp | (32'hFFFFFFFF << (8 * n));

        @(negedge clk);
        opcode = is_st ? ST : LD; funct3 = f3; mem_addr = a; wdata = d;
        wd = rd; wreg = we; valid = 1'b1; rdy = 1'b1;
        #1;
        chk("busy_accept", busy, 1);
        prev_a = mem_a; busy_cnt = 1; k = 0; paused = 0; seen = 1'b0;
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            @(negedge clk);
            valid = 1'b0;
            if (pause_mode == 1) rdy = (k < n) ? ($urandom_range(0, 2) != 0) : 1'b1;
            else if (pause_mode == 2) rdy = !(k == 2 && paused < 3);
            else rdy = 1'b1;
            #1;
            if (busy) busy_cnt++;
            if (!rdy) begin
                paused++;
                chk("pause_no_wr", mem_wr, 0);
                chk("pause_addr_hold", mem_a, prev_a);
            end else if (k < n) begin
                chk(is_st ? "st_addr" : "ld_addr", mem_a, a + k);
                if (is_st) begin
                    chk("st_wr", mem_wr, 1);
                    chk("st_byte", mem_dout, (d >> (8 * k)) & 32'hFF);
                end else begin
                    chk("ld_no_wr", mem_wr, 0);
                end
                k++;
            end
            if (wb_valid) begin
                seen = 1'b1;
                if (is_st) begin
                    chk("st_wreg", wreg_o, 0);
                    chk("st_wdata", wdata_o, 0);
                end else begin
                    chk("ld_wdata", wdata_o, exp);
                    chk("ld_wd", wd_o, rd);
                    chk("ld_wreg", wreg_o, we & (rd != 0));
                end
            end
            prev_a = mem_a;
        end
        rdy = 1'b1;
        if (!seen) chk("wb_timeout", 0, 1);
        chk("busy_cycles", busy_cnt, n + (is_st ? 2 : 3) + paused);
        @(negedge clk);
        #1;
        chk("wb_pulse", wb_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic alu_op(input logic [31:0] d, input logic [4:0] rd, input logic we);
        @(negedge clk);
        opcode = ALU; funct3 = 3'($urandom); mem_addr = $urandom; wdata = d;
        wd = rd; wreg = we; valid = 1'b1; rdy = 1'b1;
        #1;
        chk("alu_busy", busy, 0);
        @(negedge clk);
        valid = 1'b0;
        #1;
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wdata", wdata_o, d);
        chk("alu_wd", wd_o, rd);
        chk("alu_wreg", wreg_o, we & (rd != 0));
        @(negedge clk);
        #1;
        chk("alu_wb_pulse", wb_valid, 0);
    endtask

    initial begin
        int wr_cnt;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_dout", mem_dout, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_wreg", wreg_o, 0);
        chk("rst_wd", wd_o, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        mem_op(1, 3'b000, 32'h100, 32'h80, 5'd0, 1'b0, 0);          // SB 0x80
        mem_op(0, 3'b000, 32'h100, 32'h0, 5'd5, 1'b1, 0);           // LB -> FFFFFF80
        mem_op(1, 3'b001, 32'h201, 32'hF234, 5'd0, 1'b0, 0);        // SH misaligned
        mem_op(0, 3'b101, 32'h201, 32'h0, 5'd6, 1'b1, 0);           // LHU -> 0000F234
        mem_op(1, 3'b010, 32'h300, 32'hDEADBEEF, 5'd1, 1'b1, 0);    // SW
        mem_op(0, 3'b010, 32'h300, 32'h0, 5'd7, 1'b1, 0);           // LW
        mem_op(0, 3'b010, 32'hFFFFFFFE, 32'h0, 5'd8, 1'b1, 0);      // LW wrap
        mem_op(0, 3'b010, 32'h300, 32'h0, 5'd7, 1'b1, 2);           // LW paused
        mem_op(0, 3'b011, 32'h302, 32'h0, 5'd0, 1'b1, 0);           // funct3=11, wd=0
        mem_op(1, 3'b000, 32'h3FF, 32'hA5, 5'd0, 1'b0, 0);          // SB

        // SW aborted by reset after two bytes
        @(negedge clk);
        opcode = ST; funct3 = 3'b010; mem_addr = 32'h400; wdata = 32'h11223344;
        wd = 5'd0; wreg = 1'b0; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        #1;
        chk("abort_wr0", mem_wr, 1);
        @(negedge clk);
        #1;
        chk("abort_wr1", mem_wr, 1);
        ref_mem[12'h400] = 8'h44;
        ref_mem[12'h401] = 8'h33;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_rst_wr", mem_wr, 0);
        chk("abort_rst_a", mem_a, 0);
        chk("abort_rst_busy", busy, 0);
        chk("abort_rst_wb", wb_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (mem_wr || wb_valid) wr_cnt++;
        end
        chk("abort_no_stray", wr_cnt, 0);
        alu_op(32'd7, 5'd3, 1'b1);
        mem_op(0, 3'b010, 32'h400, 32'h0, 5'd9, 1'b1, 0);           // only 2 bytes landed
        alu_op(32'h1234_5678, 5'd0, 1'b1);                           // wd=0 forces wreg_o=0

        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            int kind;
            kind = $urandom_range(0, 2);
            a = ($urandom_range(0, 1) != 0) ? $urandom : (32'hFFFFFFF0 + $urandom_range(0, 15));
            if (kind == 2) alu_op($urandom, 5'($urandom_range(0, 7)), 1'($urandom));
            else mem_op(kind == 1, 3'($urandom), a, $urandom, 5'($urandom_range(0, 7)),
                        1'($urandom), $urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
